stage2_ch_acc_bias_relu: RTL
============================

Name: stage2_ch_acc_bias_relu

Overview:
Downstream neighbour of the stage-2 5x5 kernel multiply-accumulate. It consumes one kernel accumulation per input channel and sums CI consecutive results into one output-pixel value. It then adds the per-output-channel bias, applies ReLU, and rescales with rounding and saturation. The result is the O_BW-bit activation fed to the next stage (pooling / stage-3 line buffer), together with a pixel count and an end-of-frame pulse.

Parameters:
CI, 3, input channels summed per output pixel
AK_BW, 33, kernel accumulation width (signed)
ACI_BW, 35, channel-sum width, AK_BW + clog2(CI); sized so the sum cannot overflow
B_BW, 16, bias width (signed, pre-aligned to the accumulator LSB)
SHIFT, 8, arithmetic right-shift applied after bias and ReLU
O_BW, 20, output activation width (signed, always non-negative)
N_PIX, 64, output pixels per frame

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous clear of counters, accumulator and pipeline valids
i_in_valid  in  1  one kernel result presented this cycle
i_kernel_acc  in  AK_BW signed  kernel accumulation for the current channel
i_bias  in  B_BW signed  bias, sampled only on the last-channel valid
o_ot_valid  in/out=out  1  activation valid (single-cycle pulse per pixel)
o_ot_act  out  O_BW signed  activation
o_pix_idx  out  clog2(N_PIX)  index of the pixel on o_ot_act
o_frame_done  out  1  pulses together with o_ot_valid for pixel N_PIX-1

Behaviour:
- Reset (reset_n low, asynchronous): all registers and outputs are 0, ch_cnt=0, pix_cnt=0.
- No backpressure; the stream is push-only, matching the kernel stage. Idle cycles between channel valids are allowed without limit.
- Channel stage, per i_in_valid:
  - ch_cnt==0: acc <= sign-extend(i_kernel_acc).
  - otherwise: acc <= acc + i_kernel_acc.
  - ch_cnt increments and wraps to 0 after CI-1.
- On a valid with ch_cnt==CI-1: register r_sum = acc + i_kernel_acc (ACI_BW), register r_bias = i_bias, and set v1.
- Stage 2 (v1 -> v2): r_biased = r_sum + sign-extend(r_bias), width ACI_BW+1.
- Stage 3 (v2 -> o_ot_valid):
  - ReLU: a negative value gives 0.
  - Otherwise rounded = (x + 2^(SHIFT-1)) >>> SHIFT (round half up).
  - Saturate to 2^(O_BW-1)-1.
- Latency: o_ot_valid is asserted exactly 3 cycles after the clock edge that samples the last-channel valid. o_ot_act holds its value until the next output.
- Pixel counter: o_pix_idx equals pix_cnt at output time. pix_cnt increments on each o_ot_valid and wraps to 0 after N_PIX-1. o_frame_done = o_ot_valid && pix_cnt==N_PIX-1.
- i_clear:
  - Zeroes ch_cnt, acc, pix_cnt, v1, v2 and o_ot_valid at the next edge; o_ot_act is also zeroed.
  - Clear with i_in_valid in the same cycle: clear wins and the input is dropped.
  - Pixels already in the pipeline are discarded.
- Reset mid-pixel: the partial channel sum is lost and the next valid is treated as channel 0.
- Back-to-back pixels (valid every cycle): full throughput, one output every CI cycles, no bubbles.

Decomposition:
- Shared defines file (alongside the existing stage-2 core defines) gains ST2_CI, ST2_ACI_BW, ST2_B_BW, ST2_SHIFT, ST2_O_BW and ST2_N_PIX. Module parameters default to these.
- Sub-module stage2_relu_round_sat: combinational ReLU, round, shift and saturate, parameterised on input width, SHIFT and O_BW. It is instantiated before the stage-3 register and is reusable by stage 3.

Test Plan (CI=3, SHIFT=8, O_BW=20, N_PIX=4 for the bench):
1. Reset: assert reset_n=0 mid-stream -> all outputs 0 immediately; after release, the first valid is treated as channel 0.
2. Basic: acc 100, 200, 300 on consecutive cycles, bias 256 -> sum 856 -> o_ot_act=3, o_ot_valid exactly 3 cycles after the third valid, o_pix_idx=0.
3. ReLU and rounding:
   - -1000, 10, 20 with bias 0 -> 0.
   - 128, 128, 128 with bias 0 (sum 384, i.e. 1.5) -> 2.
   - 100, 0, 0 with bias 27 (sum 127) -> 0.
4. Saturation: three inputs of 2^32-1, bias 32767 -> o_ot_act=524287, with no wrap to negative.
5. Gaps and clear:
   - Channels separated by 0-5 idle cycles -> same result as the back-to-back case.
   - i_clear after two channels, then 10, 20, 30 with bias 0 -> single output 0 at pixel index 0; the pre-clear data has no effect.
   - i_clear together with a valid -> that input is ignored.
6. Frame: 8 back-to-back pixels (24 valids) -> o_ot_valid every 3 cycles, o_pix_idx sequence 0,1,2,3,0,1,2,3, o_frame_done on the 4th and 8th outputs only.

Source files
------------

// File: rtl/stage2_ch_acc_bias_relu_pkg.sv
// Shared stage-2 widths and defaults for the channel-sum / bias / ReLU back end.
// Latency: n/a (definitions only); backpressure: n/a.
package stage2_ch_acc_bias_relu_pkg;

   localparam int ST2_CI     = 3;
   localparam int ST2_AK_BW  = 33;
   // The channel sum grows by clog2(CI) bits so CI full-scale kernel results cannot overflow.
   localparam int ST2_ACI_BW = ST2_AK_BW + $clog2(ST2_CI);
   localparam int ST2_B_BW   = 16;
   localparam int ST2_SHIFT  = 8;
   localparam int ST2_O_BW   = 20;
   localparam int ST2_N_PIX  = 64;

endpackage

// File: rtl/stage2_relu_round_sat.sv
// ReLU, round-half-up arithmetic shift and saturation to a non-negative O_BW activation.
// Latency: combinational; backpressure: none.
module stage2_relu_round_sat
   import stage2_ch_acc_bias_relu_pkg::*;
#(
   parameter int IN_W  = ST2_ACI_BW + 1,
   parameter int SHIFT = ST2_SHIFT,
   parameter int O_BW  = ST2_O_BW
) (
   input  logic signed [IN_W-1:0] x,
   output logic signed [O_BW-1:0] act
);

   // One guard bit keeps x + half-LSB from wrapping at the positive extreme.
   localparam int W = IN_W + 1;
   localparam logic signed [W-1:0] RND     = $signed({{(W-1){1'b0}}, 1'b1} << (SHIFT - 1));
   localparam logic signed [W-1:0] ACT_MAX = $signed({{(W-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}});

   logic signed [W-1:0] x_ext;
   logic signed [W-1:0] rounded;

   always_comb begin
      x_ext   = {x[IN_W-1], x};
      rounded = (x_ext + RND) >>> SHIFT;
      act     = '0;
      if (!x[IN_W-1]) begin
         if (rounded > ACT_MAX) begin
            act = ACT_MAX[O_BW-1:0];
         end else begin
            act = rounded[O_BW-1:0];
         end
      end
   end

endmodule

// File: rtl/stage2_ch_acc_bias_relu.sv
// Sums CI kernel results per pixel, adds bias, ReLU/round/saturate, tags pixel index and end of frame.
// Latency: 3 cycles from the last-channel valid to o_ot_valid; backpressure: none (push-only stream).
module stage2_ch_acc_bias_relu
   import stage2_ch_acc_bias_relu_pkg::*;
#(
   parameter int CI     = ST2_CI,
   parameter int AK_BW  = ST2_AK_BW,
   parameter int ACI_BW = ST2_ACI_BW,
   parameter int B_BW   = ST2_B_BW,
   parameter int SHIFT  = ST2_SHIFT,
   parameter int O_BW   = ST2_O_BW,
   parameter int N_PIX  = ST2_N_PIX,
   localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_clear,
   input  logic                    i_in_valid,
   input  logic signed [AK_BW-1:0] i_kernel_acc,
   input  logic signed [B_BW-1:0]  i_bias,
   output logic                    o_ot_valid,
   output logic signed [O_BW-1:0]  o_ot_act,
   output logic [PIX_W-1:0]        o_pix_idx,
   output logic                    o_frame_done
);

   localparam int               CH_W     = (CI > 1) ? $clog2(CI) : 1;
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CI - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

   logic                     in_vld;
   logic signed [AK_BW-1:0]  in_kacc;
   logic signed [B_BW-1:0]   in_bias;

   logic [CH_W-1:0]          ch_cnt;
   logic signed [ACI_BW-1:0] acc;
   logic signed [ACI_BW-1:0] kacc_ext;
   logic signed [ACI_BW-1:0] sum_nxt;
   logic signed [ACI_BW-1:0] r_sum;
   logic signed [B_BW-1:0]   r_bias;
   logic                     v1;

   logic signed [ACI_BW:0]   r_biased;
   logic                     v2;

   logic signed [O_BW-1:0]   act_nxt;
   logic [PIX_W-1:0]         pix_cnt;

   // Boundary register: the channel stage works on the registered input, which sets the 3-cycle latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_vld  <= 1'b0;
         in_kacc <= '0;
         in_bias <= '0;
      end else if (i_clear) begin
         in_vld  <= 1'b0;
      end else begin
         in_vld <= i_in_valid;
         if (i_in_valid) begin
            in_kacc <= i_kernel_acc;
            in_bias <= i_bias;
         end
      end
   end

   always_comb begin
      kacc_ext = {{(ACI_BW-AK_BW){in_kacc[AK_BW-1]}}, in_kacc};
      sum_nxt  = (ch_cnt == '0) ? kacc_ext : acc + kacc_ext;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch_cnt <= '0;
         acc    <= '0;
         r_sum  <= '0;
         r_bias <= '0;
         v1     <= 1'b0;
      end else if (i_clear) begin
         ch_cnt <= '0;
         acc    <= '0;
         v1     <= 1'b0;
      end else begin
         v1 <= 1'b0;
         if (in_vld) begin
            if (ch_cnt == CH_LAST) begin
               r_sum  <= sum_nxt;
               r_bias <= in_bias;
               v1     <= 1'b1;
               ch_cnt <= '0;
            end else begin
               acc    <= sum_nxt;
               ch_cnt <= ch_cnt + CH_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_biased <= '0;
         v2       <= 1'b0;
      end else if (i_clear) begin
         v2       <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            r_biased <= {r_sum[ACI_BW-1], r_sum}
                        + {{(ACI_BW+1-B_BW){r_bias[B_BW-1]}}, r_bias};
         end
      end
   end

   stage2_relu_round_sat #(
      .IN_W  (ACI_BW + 1),
      .SHIFT (SHIFT),
      .O_BW  (O_BW)
   ) u_relu_round_sat (
      .x   (r_biased),
      .act (act_nxt)
   );

   // o_ot_act and o_pix_idx hold between outputs; only the valid and frame pulse drop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_ot_valid   <= 1'b0;
         o_ot_act     <= '0;
         o_pix_idx    <= '0;
         o_frame_done <= 1'b0;
         pix_cnt      <= '0;
      end else if (i_clear) begin
         o_ot_valid   <= 1'b0;
         o_ot_act     <= '0;
         o_pix_idx    <= '0;
         o_frame_done <= 1'b0;
         pix_cnt      <= '0;
      end else begin
         o_ot_valid   <= v2;
         o_frame_done <= v2 && (pix_cnt == PIX_LAST);
         if (v2) begin
            o_ot_act  <= act_nxt;
            o_pix_idx <= pix_cnt;
            pix_cnt   <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PIX_W'(1);
         end
      end
   end

endmodule
